// File: rtl/seq_gen_if.sv
// seq_gen_if: control/data bundle between a pattern-source user and seq_gen.
// master drives requests and the pattern; slave (seq_gen) drives the serial stream.
interface seq_gen_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             load_pat;
  logic [WIDTH-1:0] pat_in;
  logic [CNT_W-1:0] repeat_cnt;
  logic             seq_out;
  logic             valid_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start, load_pat, pat_in, repeat_cnt,
    input  seq_out, valid_o, busy_o, done_o
  );

  modport slave (
    input  start, load_pat, pat_in, repeat_cnt,
    output seq_out, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter, MSB-first, N frames with optional zero gap.
// Feeds the 1011 sequence detector. Optional per-frame even parity bit is
// enabled by defining SEQ_GEN_PARITY_EN.
// All outputs are registered: next-state values are computed combinationally
// and the outputs are loaded from them, so the first bit shows up the cycle
// right after start is sampled.
module seq_gen #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] PATTERN  = 4'b1011,
  parameter int               CNT_W    = 8,
  parameter int               GAP_BITS = 0
) (
  input  logic       clk,
  input  logic       rst,
  seq_gen_if.slave   bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;

`ifdef SEQ_GEN_PARITY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    PAR   = 3'd3,
    DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    DONE  = 3'd4
  } state_t;
`endif

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] frames_q, frames_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic             seq_q, seq_n;
  logic             valid_q, valid_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             frame_end;
  logic             more;

  // State, counters, pattern and registered outputs; async reset clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      frames_q <= '0;
      gap_q    <= '0;
      pat_q    <= PATTERN;
      seq_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      frames_q <= frames_n;
      gap_q    <= gap_n;
      pat_q    <= pat_n;
      seq_q    <= seq_n;
      valid_q  <= valid_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state logic plus the output values that the next state will present.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    frames_n  = frames_q;
    gap_n     = gap_q;
    pat_n     = pat_q;
    frame_end = 1'b0;
    more      = 1'b0;

    case (state_q)
      IDLE: begin
        // Requests are only honoured here; a simultaneous load feeds this run.
        if (bus.load_pat) pat_n = bus.pat_in;
        if (bus.start) begin
          state_n  = SHIFT;
          idx_n    = IDX_LAST;
          frames_n = (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_n = idx_q - IDX_W'(1);
        end else begin
          // frames_q >= 1 here, so the decrement cannot wrap.
          frames_n = frames_q - CNT_W'(1);
`ifdef SEQ_GEN_PARITY_EN
          state_n = PAR;
`else
          frame_end = 1'b1;
          more      = (frames_q > CNT_W'(1));
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR: begin
        // Frame count was already decremented on the last data bit.
        frame_end = 1'b1;
        more      = (frames_q != '0);
      end
`endif
      GAP: begin
        if (gap_q == '0) begin
          state_n = SHIFT;
          idx_n   = IDX_LAST;
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Common end-of-frame routing: gap, back-to-back next frame, or finish.
    if (frame_end) begin
      if (more) begin
        if (GAP_BITS > 0) begin
          state_n = GAP;
          gap_n   = GAP_LAST;
        end else begin
          state_n = SHIFT;
          idx_n   = IDX_LAST;
        end
      end else begin
        state_n = DONE;
      end
    end
  end

  // Output values for the upcoming state, loaded into the output registers.
  always_comb begin
    seq_n   = 1'b0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state_n)
      SHIFT: begin
        seq_n   = pat_n[idx_n];
        valid_n = 1'b1;
        busy_n  = 1'b1;
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR: begin
        seq_n   = ^pat_n;
        valid_n = 1'b1;
        busy_n  = 1'b1;
      end
`endif
      GAP:     busy_n = 1'b1;
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  assign bus.seq_out = seq_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed checks of seq_gen. Two instances: A back-to-back
// (GAP_BITS=0), B with a two-bit gap. Expected streams are written out by hand;
// cycle 1 is the first cycle after the edge that samples start, and captured
// vectors hold cycle 1 in their most significant used bit.
module tb_seq_gen;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_gen_if #(.WIDTH(4), .CNT_W(8)) ia ();
  seq_gen_if #(.WIDTH(4), .CNT_W(8)) ib ();

  seq_gen #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(8), .GAP_BITS(0))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  seq_gen #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(8), .GAP_BITS(2))
    u_b (.clk(clk), .rst(rst), .bus(ib));

  int checks = 0;
  int errors = 0;
  logic [63:0] gs, gv, gb, gd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0b exp %0b", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic ld,
                       input logic [3:0] pin, input logic [7:0] rc);
    if (sel == 0) begin
      ia.start = st; ia.load_pat = ld; ia.pat_in = pin; ia.repeat_cnt = rc;
    end else begin
      ib.start = st; ib.load_pat = ld; ib.pat_in = pin; ib.repeat_cnt = rc;
    end
  endtask

  task automatic step(input int sel);
    logic [3:0] o;
    @(posedge clk); #1;
    o = (sel == 0) ? {ia.seq_out, ia.valid_o, ia.busy_o, ia.done_o}
                   : {ib.seq_out, ib.valid_o, ib.busy_o, ib.done_o};
    gs = {gs[62:0], o[3]};
    gv = {gv[62:0], o[2]};
    gb = {gb[62:0], o[1]};
    gd = {gd[62:0], o[0]};
  endtask

  task automatic clr();
    gs = '0; gv = '0; gb = '0; gd = '0;
  endtask

  task automatic run(input int sel, input logic ld, input logic [3:0] pin,
                     input logic [7:0] rc, input int n);
    clr();
    @(negedge clk);
    drive(sel, 1'b1, ld, pin, rc);
    for (int c = 1; c <= n; c++) begin
      step(sel);
      if (c == 1) drive(sel, 1'b0, 1'b0, pin, rc);
    end
  endtask

  // Overlapping 1011 detector over the captured serial stream.
  function automatic int det_cnt(input logic [63:0] x, input int n);
    int cnt = 0;
    for (int i = n - 1; i >= 3; i--)
      if (x[i -: 4] == 4'b1011) cnt++;
    return cnt;
  endfunction

  initial begin
    logic [63:0] t1_seq, t1_vld, t1_done;
    int nb, nd;
    t1_seq  = PB ? 64'b1011100 : 64'b101100;
    t1_vld  = PB ? 64'b1111100 : 64'b111100;
    t1_done = PB ? 64'b0000010 : 64'b000010;
    drive(0, 1'b0, 1'b0, 4'b0000, 8'd0);
    drive(1, 1'b0, 1'b0, 4'b0000, 8'd0);

    // Reset state
    #12;
    chk("rst_a", {ia.seq_out, ia.valid_o, ia.busy_o, ia.done_o}, 4'b0000);
    chk("rst_b", {ib.seq_out, ib.valid_o, ib.busy_o, ib.done_o}, 4'b0000);
    @(negedge clk); rst = 1'b0;

    // Default pattern, one frame
    run(0, 1'b0, 4'b0000, 8'd1, 6 + PB);
    chk("t1_seq", gs, t1_seq);
    chk("t1_vld", gv, t1_vld);
    chk("t1_busy", gb, t1_vld);
    chk("t1_done", gd, t1_done);
    chk("t1_det", det_cnt(gs, 6 + PB), 1);

    // Load 0110, then three back-to-back frames
    @(negedge clk); drive(0, 1'b0, 1'b1, 4'b0110, 8'd0);
    @(negedge clk); drive(0, 1'b0, 1'b0, 4'b0000, 8'd0);
    run(0, 1'b0, 4'b0000, 8'd3, 14 + 3 * PB);
    chk("t2_seq", gs, PB ? 64'b01100011000110000 : 64'b01100110011000);
    chk("t2_vld", gv, PB ? 64'b11111111111111100 : 64'b11111111111100);
    chk("t2_busy", gb, PB ? 64'b11111111111111100 : 64'b11111111111100);
    chk("t2_done", gd, PB ? 64'b00000000000000010 : 64'b00000000000010);

    // Two-bit gap instance, two frames of the default pattern
    run(1, 1'b0, 4'b0000, 8'd2, 12 + 2 * PB);
    chk("t3_seq", gs, PB ? 64'b10111001011100 : 64'b101100101100);
    chk("t3_vld", gv, PB ? 64'b11111001111100 : 64'b111100111100);
    chk("t3_busy", gb, PB ? 64'b11111111111100 : 64'b111111111100);
    chk("t3_done", gd, PB ? 64'b00000000000010 : 64'b000000000010);
    chk("t3_det", det_cnt(gs, 12 + 2 * PB), 2);

    // Async reset on the 3rd bit of frame 2 (pattern 0110, that bit is 1)
    run(0, 1'b0, 4'b0000, 8'd2, 7 + PB);
    chk("t4_pre", {gs[0], gv[0], gb[0]}, 3'b111);
    rst = 1'b1; #1;
    chk("t4_async", {ia.seq_out, ia.valid_o, ia.busy_o, ia.done_o}, 4'b0000);
    @(posedge clk); #1;
    chk("t4_hold", {ia.seq_out, ia.valid_o, ia.busy_o, ia.done_o}, 4'b0000);
    @(negedge clk); rst = 1'b0;
    run(0, 1'b0, 4'b0000, 8'd1, 6 + PB);
    chk("t4_pat", gs, t1_seq);

    // repeat_cnt=0 is one frame; start/load during the run are ignored
    clr();
    @(negedge clk); drive(0, 1'b1, 1'b0, 4'b0000, 8'd0);
    for (int c = 1; c <= 6 + PB; c++) begin
      step(0);
      if (c == 1) drive(0, 1'b0, 1'b0, 4'b0000, 8'd0);
      if (c == 2) drive(0, 1'b1, 1'b1, 4'b0000, 8'd5);
      if (c == 3) drive(0, 1'b0, 1'b0, 4'b0000, 8'd0);
    end
    chk("t5_seq", gs, t1_seq);
    chk("t5_busy", gb, t1_vld);
    chk("t5_done", gd, t1_done);
    run(0, 1'b0, 4'b0000, 8'd1, 6 + PB);
    chk("t5_pat", gs, t1_seq);

    // start together with load_pat uses the new pattern (1001, parity 0)
    run(0, 1'b1, 4'b1001, 8'd1, 6 + PB);
    chk("t6_seq", gs, PB ? 64'b1001000 : 64'b100100);
    chk("t6_done", gd, t1_done);

    // Maximum repeat count: 255 frames, no wrap, single done
    clr();
    nb = 0; nd = 0;
    @(negedge clk); drive(0, 1'b1, 1'b0, 4'b0000, 8'd255);
    for (int c = 1; c <= 3000; c++) begin
      step(0);
      if (c == 1) drive(0, 1'b0, 1'b0, 4'b0000, 8'd0);
      nb += int'(gb[0]);
      if (gd[0]) begin
        nd++;
        break;
      end
    end
    chk("t7_done_seen", nd, 1);
    chk("t7_busy_cycles", nb, PB ? 1275 : 1020);
    step(0);
    chk("t7_after", {gs[0], gv[0], gb[0], gd[0]}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
